loop_counter: RTL
=================

Name: loop_counter

Overview:
- Sequential loop-index stage for the HLS datapath. It consumes the registered output of an incrementer and feeds it back, walking an index from init to limit inclusive.
- Each index value is offered downstream over a valid/ready handshake.
- Signals completion with a one-cycle done pulse. Used by generated control for for-loops.

Parameters:
DATAWIDTH, 8, width of init, limit and count (unsigned).

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-low reset.
start  input  1  begin a loop; sampled only in IDLE.
init  input  DATAWIDTH  first index; sampled on accepted start.
limit  input  DATAWIDTH  last index (inclusive); sampled on accepted start.
out_ready  input  1  downstream accepts current count.
count  output  DATAWIDTH  current index.
out_valid  output  1  count is a valid index.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle completion pulse.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (Rst).
- Reset (Rst=0, asynchronous): state=IDLE, count=0, limit register=0, out_valid=0, busy=0, done=0. This applies mid-loop: the loop is abandoned and no done pulse is issued.
- States are IDLE, RUN and DONE. All outputs are registered or decoded from state; there are no combinational in-to-out paths except as noted.
- IDLE:
  - On start=1, capture init into count and limit into limit_q.
  - If init <= limit (unsigned), next state is RUN. Otherwise next state is DONE, and no index is ever offered.
- RUN:
  - out_valid=1 and count holds stable until the transfer (out_valid & out_ready).
  - On transfer with count==limit_q: next state is DONE and count holds.
  - On transfer with count!=limit_q: count <= count+1 (DATAWIDTH bits, mod 2^DATAWIDTH). The wrap is unreachable because count<limit_q.
  - Without a transfer, everything holds.
  - Back-to-back transfers give one index per cycle.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. A start in the same cycle as done (DONE state) is ignored, so the earliest restart is the following cycle in IDLE.
- Latency:
  - start to first out_valid is 1 cycle.
  - Last transfer to done is 1 cycle.
  - A full loop of N indices with out_ready held high takes N+2 cycles from start to done-deassert.
- init==limit yields exactly one index.
- init=0, limit=2^DATAWIDTH-1 yields all 2^DATAWIDTH indices, and termination is by the equality compare, not by overflow.

Optional Feature:
- Macro LOOP_COUNTER_ABORT_EN.
- When defined, an extra input port abort (1 bit) is added after out_ready.
  - abort=1 in RUN forces next state DONE. count holds, and a coincident transfer still completes.
  - abort is ignored in IDLE and DONE.
  - done pulses normally.
- When undefined, the port does not exist and behaviour is exactly as above.

Decomposition:
- Shared package loop_counter_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - state width constant STATE_W=2.
- One sub-module: a single inc instance (DATAWIDTH passed through) computes count+1. The next-state mux and registers remain in loop_counter.

Test Plan:
- Reset, then start with init=3, limit=6 and out_ready=1 held: count 3,4,5,6 with out_valid on 4 consecutive cycles, then done=1 for 1 cycle, then busy=0.
- Same start with out_ready toggling 1,0,0,1,...: count stays stable while out_ready=0, the exact sequence 3..6 is delivered with no duplicates or skips, and there is a single done pulse.
- init=5, limit=5: one transfer of 5, then done. init=9, limit=4: no out_valid ever, done one cycle after start.
- DATAWIDTH=8, init=0, limit=255: 256 transfers 0..255, no wrap to 0, done after the 255 transfer. Assert Rst=0 mid-loop at count=100: outputs clear immediately (asynchronously) and no done pulse follows.
- start pulses while busy (at count=4), and start in the DONE cycle: both ignored; no state or count change. With LOOP_COUNTER_ABORT_EN, abort at count=4 without a transfer: DONE next cycle with count=4 and one done pulse.

Source files
------------

// File: rtl/loop_counter_pkg.sv
// loop_counter shared definitions: state encoding and widths.
// Optional abort input is enabled by LOOP_COUNTER_ABORT_EN.
package loop_counter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/loop_counter_if.sv
// loop_counter handshake bundle: start/bounds in, index stream out.
// Optional abort signal is present when LOOP_COUNTER_ABORT_EN is defined.
interface loop_counter_if #(
  parameter int DATAWIDTH = 8
);

  logic                 start;
  logic [DATAWIDTH-1:0] init;
  logic [DATAWIDTH-1:0] limit;
  logic                 out_ready;
`ifdef LOOP_COUNTER_ABORT_EN
  logic                 abort;
`endif
  logic [DATAWIDTH-1:0] count;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

`ifdef LOOP_COUNTER_ABORT_EN
  modport master (
    output start, init, limit, out_ready, abort,
    input  count, out_valid, busy, done
  );

  modport slave (
    input  start, init, limit, out_ready, abort,
    output count, out_valid, busy, done
  );
`else
  modport master (
    output start, init, limit, out_ready,
    input  count, out_valid, busy, done
  );

  modport slave (
    input  start, init, limit, out_ready,
    output count, out_valid, busy, done
  );
`endif

endinterface

// File: rtl/loop_counter_inc.sv
// loop_counter incrementer: produces count+1, wrapping mod 2^DATAWIDTH.
// Termination is decided by the caller's equality compare, not this wrap.
module loop_counter_inc
  import loop_counter_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a_i,
  output logic [DATAWIDTH-1:0] y_o
);

  assign y_o = a_i + DATAWIDTH'(1);

endmodule

// File: rtl/loop_counter.sv
// loop_counter: walks an index from init to limit inclusive over valid/ready.
// Define LOOP_COUNTER_ABORT_EN to add an abort input that ends a loop early.
module loop_counter
  import loop_counter_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input logic          Clk,
  input logic          Rst,
  loop_counter_if.slave bus
);

  state_t               state_q;
  state_t               state_d;
  logic [DATAWIDTH-1:0] count_q;
  logic [DATAWIDTH-1:0] count_d;
  logic [DATAWIDTH-1:0] limit_q;
  logic [DATAWIDTH-1:0] limit_d;
  logic [DATAWIDTH-1:0] count_inc;
  logic                 xfer;

  loop_counter_inc #(
    .DATAWIDTH(DATAWIDTH)
  ) u_inc (
    .a_i(count_q),
    .y_o(count_inc)
  );

  assign xfer = (state_q == S_RUN) & bus.out_ready;

  // Next-state, next-count and bound capture.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          count_d = bus.init;
          limit_d = bus.limit;
          if (bus.init <= bus.limit) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (count_q == limit_q) begin
            state_d = S_DONE;
          end else begin
            count_d = count_inc;
          end
        end
`ifdef LOOP_COUNTER_ABORT_EN
        if (bus.abort) begin
          state_d = S_DONE;
          count_d = count_q;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, index and bound registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.out_valid = (state_q == S_RUN);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule
